// File: rtl/acl2_sample_assembler.sv
// Assembles the six-byte ADXL362 burst (XDATA_L..ZDATA_H) into signed 12-bit X/Y/Z samples,
// checks frame length and sign-extension, and keeps sample/error counters.
module acl2_sample_assembler #(
  parameter int COUNT_WIDTH = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FRAME_START,
  input  logic                   FRAME_END,
  input  logic                   BYTE_VALID,
  input  logic [7:0]             BYTE_DATA,
  output logic [11:0]            X_DATA,
  output logic [11:0]            Y_DATA,
  output logic [11:0]            Z_DATA,
  output logic [2:0]             AXIS_FAULT,
  output logic                   SAMPLE_VALID,
  output logic                   FRAME_ERROR,
  output logic [COUNT_WIDTH-1:0] SAMPLE_COUNT,
  output logic [ERR_WIDTH-1:0]   ERROR_COUNT,
  output logic                   BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WAIT_END
  } state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             index_reg, index_next;
  logic                   overrun_reg, overrun_next;
  logic [7:0]             stage_reg [0:5];
  logic [7:0]             stage_next [0:5];
  logic [11:0]            axis_reg [0:2];
  logic [11:0]            sample_next [0:2];
  logic [2:0]             fault_reg, fault_next;
  logic                   sample_valid_reg, frame_error_reg;
  logic [COUNT_WIDTH-1:0] sample_count_reg;
  logic [ERR_WIDTH-1:0]   error_count_reg;

  logic publish, discard, frame_full, old_byte, frame_active;

  // A byte that coincides with FRAME_START belongs to the new frame, never the old one.
  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    overrun_next = overrun_reg;
    for (int i = 0; i < 6; i++) stage_next[i] = stage_reg[i];
    publish      = 1'b0;
    discard      = 1'b0;
    frame_full   = 1'b0;
    old_byte     = BYTE_VALID && !FRAME_START;
    frame_active = (state_reg != ST_IDLE);

    if (state_reg == ST_COLLECT && old_byte) begin
      stage_next[index_reg] = BYTE_DATA;
      if (index_reg == 3'd5) frame_full = 1'b1;
      else                   index_next = index_reg + 3'd1;
    end

    if (state_reg == ST_WAIT_END && old_byte) overrun_next = 1'b1;

    // The old frame is always resolved before a coincident FRAME_START opens a new one.
    if (frame_active && FRAME_END) begin
      if (frame_full || (state_reg == ST_WAIT_END && !overrun_next)) publish = 1'b1;
      else                                                          discard = 1'b1;
      state_next   = ST_IDLE;
      index_next   = 3'd0;
      overrun_next = 1'b0;
    end else if (frame_full) begin
      state_next = ST_WAIT_END;
      index_next = 3'd0;
    end else if (frame_active && FRAME_START) begin
      discard = 1'b1;
    end

    if (FRAME_START) begin
      state_next   = ST_COLLECT;
      overrun_next = 1'b0;
      if (BYTE_VALID) begin
        stage_next[0] = BYTE_DATA;
        index_next    = 3'd1;
      end else begin
        index_next = 3'd0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      assign sample_next[gi] = {stage_next[2*gi+1][3:0], stage_next[2*gi]};
      assign fault_next[gi]  = (stage_next[2*gi+1][7:4] != {4{stage_next[2*gi+1][3]}});
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg        <= ST_IDLE;
      index_reg        <= 3'd0;
      overrun_reg      <= 1'b0;
      for (int i = 0; i < 6; i++) stage_reg[i] <= 8'd0;
      for (int i = 0; i < 3; i++) axis_reg[i] <= 12'd0;
      fault_reg        <= 3'd0;
      sample_valid_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
      sample_count_reg <= '0;
      error_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      index_reg        <= index_next;
      overrun_reg      <= overrun_next;
      for (int i = 0; i < 6; i++) stage_reg[i] <= stage_next[i];
      sample_valid_reg <= publish;
      frame_error_reg  <= discard;
      if (publish) begin
        for (int i = 0; i < 3; i++) axis_reg[i] <= sample_next[i];
        fault_reg        <= fault_next;
        sample_count_reg <= sample_count_reg + COUNT_WIDTH'(1);
      end
      if (discard && (error_count_reg != {ERR_WIDTH{1'b1}})) begin
        error_count_reg <= error_count_reg + ERR_WIDTH'(1);
      end
    end
  end

  assign X_DATA       = axis_reg[0];
  assign Y_DATA       = axis_reg[1];
  assign Z_DATA       = axis_reg[2];
  assign AXIS_FAULT   = fault_reg;
  assign SAMPLE_VALID = sample_valid_reg;
  assign FRAME_ERROR  = frame_error_reg;
  assign SAMPLE_COUNT = sample_count_reg;
  assign ERROR_COUNT  = error_count_reg;
  assign BUSY         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_acl2_sample_assembler.sv
// Directed bench for acl2_sample_assembler: normal, faulted, short, overrun and
// coincident-event frames, counter wrap/saturation and asynchronous reset.
module tb_acl2_sample_assembler;
  localparam int CW = 4;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          FRAME_START = 1'b0;
  logic          FRAME_END = 1'b0;
  logic          BYTE_VALID = 1'b0;
  logic [7:0]    BYTE_DATA = 8'd0;
  logic [11:0]   X_DATA, Y_DATA, Z_DATA;
  logic [2:0]    AXIS_FAULT;
  logic          SAMPLE_VALID, FRAME_ERROR, BUSY;
  logic [CW-1:0] SAMPLE_COUNT;
  logic [EW-1:0] ERROR_COUNT;

  acl2_sample_assembler #(.COUNT_WIDTH(CW), .ERR_WIDTH(EW)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .FRAME_END(FRAME_END),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .X_DATA(X_DATA), .Y_DATA(Y_DATA),
    .Z_DATA(Z_DATA), .AXIS_FAULT(AXIS_FAULT), .SAMPLE_VALID(SAMPLE_VALID),
    .FRAME_ERROR(FRAME_ERROR), .SAMPLE_COUNT(SAMPLE_COUNT), .ERROR_COUNT(ERROR_COUNT),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;
  int sv_seen = 0;
  int fe_seen = 0;
  logic busy_after_start, busy_after_end;
  logic [7:0] fb [0:6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock with the given inputs; strobes seen after the edge are tallied.
  task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] d);
    FRAME_START = s; FRAME_END = e; BYTE_VALID = v; BYTE_DATA = d;
    @(posedge CLK); #1;
    FRAME_START = 1'b0; FRAME_END = 1'b0; BYTE_VALID = 1'b0; BYTE_DATA = 8'd0;
    sv_seen += int'(SAMPLE_VALID);
    fe_seen += int'(FRAME_ERROR);
  endtask

  task automatic set_fb(input logic [7:0] a, b, c, d, e, f, g);
    fb[0] = a; fb[1] = b; fb[2] = c; fb[3] = d; fb[4] = e; fb[5] = f; fb[6] = g;
  endtask

  task automatic frame(input int n, input bit end_with_last);
    sv_seen = 0; fe_seen = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    busy_after_start = BUSY;
    for (int i = 0; i < n; i++) cyc(1'b0, end_with_last && (i == n - 1), 1'b1, fb[i]);
    if (!end_with_last) cyc(1'b0, 1'b1, 1'b0, 8'd0);
    busy_after_end = BUSY;
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    $display("frame %0d bytes: X=%03h Y=%03h Z=%03h fault=%b sv=%0d fe=%0d sc=%0d ec=%0d",
             n, X_DATA, Y_DATA, Z_DATA, AXIS_FAULT, sv_seen, fe_seen, SAMPLE_COUNT, ERROR_COUNT);
  endtask

  initial begin
    #1 RESET = 1'b1;
    #7;
    check("rst_x", X_DATA, 0);
    check("rst_fault", AXIS_FAULT, 0);
    check("rst_sv", SAMPLE_VALID, 0);
    check("rst_fe", FRAME_ERROR, 0);
    check("rst_sc", SAMPLE_COUNT, 0);
    check("rst_ec", ERROR_COUNT, 0);
    check("rst_busy", BUSY, 0);
    #4 RESET = 1'b0;
    @(posedge CLK); #1;

    // Normal frame
    set_fb(8'h34, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hF8, 8'h00);
    frame(6, 1'b0);
    check("norm_x", X_DATA, 12'h134);
    check("norm_y", Y_DATA, 12'hFFF);
    check("norm_z", Z_DATA, 12'h800);
    check("norm_fault", AXIS_FAULT, 3'b000);
    check("norm_sv", sv_seen, 1);
    check("norm_fe", fe_seen, 0);
    check("norm_sc", SAMPLE_COUNT, 1);
    check("norm_busy_start", busy_after_start, 1);
    check("norm_busy_end", busy_after_end, 0);

    // Sign fault on X
    set_fb(8'h34, 8'h51, 8'hFF, 8'hFF, 8'h00, 8'hF8, 8'h00);
    frame(6, 1'b0);
    check("fault_x", X_DATA, 12'h134);
    check("fault_bits", AXIS_FAULT, 3'b001);
    check("fault_sc", SAMPLE_COUNT, 2);

    // Short frame
    set_fb(8'h11, 8'h02, 8'h33, 8'h04, 8'h00, 8'h00, 8'h00);
    frame(4, 1'b0);
    check("short_fe", fe_seen, 1);
    check("short_sv", sv_seen, 0);
    check("short_ec", ERROR_COUNT, 1);
    check("short_x", X_DATA, 12'h134);
    check("short_fault", AXIS_FAULT, 3'b001);

    // Overrun, then FRAME_START with a byte on the same edge
    set_fb(8'h22, 8'h03, 8'h44, 8'h05, 8'h66, 8'h07, 8'h99);
    frame(7, 1'b0);
    check("ovr_fe", fe_seen, 1);
    check("ovr_sv", sv_seen, 0);
    check("ovr_ec", ERROR_COUNT, 2);
    check("ovr_y", Y_DATA, 12'hFFF);
    sv_seen = 0; fe_seen = 0;
    cyc(1'b1, 1'b0, 1'b1, 8'h78);
    cyc(1'b0, 1'b0, 1'b1, 8'h07);
    cyc(1'b0, 1'b0, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'h0F);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    $display("start+byte frame: X=%03h Y=%03h Z=%03h fault=%b", X_DATA, Y_DATA, Z_DATA, AXIS_FAULT);
    check("sb_x", X_DATA, 12'h778);
    check("sb_y", Y_DATA, 12'h055);
    check("sb_z", Z_DATA, 12'hFAA);
    check("sb_fault", AXIS_FAULT, 3'b100);
    check("sb_sv", sv_seen, 1);
    check("sb_sc", SAMPLE_COUNT, 3);

    // Sixth byte coincident with FRAME_END
    set_fb(8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00);
    frame(6, 1'b1);
    check("last_end_x", X_DATA, 12'h001);
    check("last_end_z", Z_DATA, 12'h003);
    check("last_end_sv", sv_seen, 1);
    check("last_end_sc", SAMPLE_COUNT, 4);

    // FRAME_START mid-frame discards the partial frame and restarts
    sv_seen = 0; fe_seen = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'hEE);
    cyc(1'b0, 1'b0, 1'b1, 8'h0E);
    set_fb(8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h00);
    frame(6, 1'b0);
    check("restart_fe", fe_seen, 1);
    check("restart_ec", ERROR_COUNT, 3);
    check("restart_y", Y_DATA, 12'h020);
    check("restart_sc", SAMPLE_COUNT, 5);

    // SAMPLE_COUNT wrap with a 4-bit counter
    for (int k = 0; k < 10; k++) frame(6, 1'b0);
    check("wrap_pre", SAMPLE_COUNT, 15);
    frame(6, 1'b0);
    check("wrap_post", SAMPLE_COUNT, 0);

    // ERROR_COUNT saturation
    for (int k = 0; k < 252; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 1'b0, 8'd0);
    end
    $display("after 252 empty frames: ec=%0d", ERROR_COUNT);
    check("sat_reach", ERROR_COUNT, 8'hFF);
    fe_seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 1'b0, 8'd0);
    end
    $display("after 260 empty frames: ec=%0d fe=%0d", ERROR_COUNT, fe_seen);
    check("sat_hold", ERROR_COUNT, 8'hFF);
    check("sat_pulses", fe_seen, 8);

    // Asynchronous reset between bytes 3 and 4
    set_fb(8'h34, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hF8, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, fb[i]);
    #2 RESET = 1'b1;
    #1;
    $display("async reset: X=%03h sc=%0d ec=%0d busy=%b", X_DATA, SAMPLE_COUNT, ERROR_COUNT, BUSY);
    check("arst_x", X_DATA, 0);
    check("arst_y", Y_DATA, 0);
    check("arst_fault", AXIS_FAULT, 0);
    check("arst_ec", ERROR_COUNT, 0);
    check("arst_busy", BUSY, 0);
    RESET = 1'b0;
    sv_seen = 0; fe_seen = 0;
    for (int i = 3; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, fb[i]);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    check("arst_idle_fe", fe_seen, 0);
    check("arst_idle_sv", sv_seen, 0);
    frame(6, 1'b0);
    check("arst_sc", SAMPLE_COUNT, 1);
    check("arst_x2", X_DATA, 12'h134);
    check("arst_ec2", ERROR_COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/acl2_sample_assembler.md
# acl2_sample_assembler

Consumes the byte stream returned by the SPI controller during an ADXL362 (Pmod ACL2) burst read starting at register 0x0E. It assembles XDATA_L…ZDATA_H into three signed 12-bit samples and checks frame length and sign-extension integrity. It publishes a coherent X/Y/Z triple with a one-cycle strobe and maintains sample and error counters. It sits directly downstream of the SPI controller and upstream of the display/logic that uses acceleration data.

## Interface
- COUNT_WIDTH, 16, width of SAMPLE_COUNT; wraps modulo 2^COUNT_WIDTH
- ERR_WIDTH, 8, width of ERROR_COUNT; saturates at all-ones
- CLK  input  1  system clock; all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- FRAME_START  input  1  one-cycle pulse when the controller drops CS for a burst
- FRAME_END  input  1  one-cycle pulse when the controller raises CS
- BYTE_VALID  input  1  one-cycle pulse: BYTE_DATA holds a received MISO byte
- BYTE_DATA  input  8  received byte, valid only with BYTE_VALID
- X_DATA, Y_DATA, Z_DATA  output  12 each  last published samples, two's complement
- AXIS_FAULT  output  3  {Z,Y,X} sign-extension fault flags of last published sample
- SAMPLE_VALID  output  1  one-cycle pulse when X/Y/Z/AXIS_FAULT update
- FRAME_ERROR  output  1  one-cycle pulse when a frame is discarded
- SAMPLE_COUNT  output  COUNT_WIDTH  number of published samples
- ERROR_COUNT  output  ERR_WIDTH  number of discarded frames, saturating
- BUSY  output  1  high in COLLECT or WAIT_END

## Operation
- Byte order within a frame: index 0..5 = XL, XH, YL, YH, ZL, ZH. Sample = {H[3:0], L[7:0]}.
- Sign check per axis: H[7:4] must equal {4{H[3]}}; mismatch sets that axis's AXIS_FAULT bit. The sample is still published.
- States:
  - IDLE: wait for FRAME_START, then go to COLLECT with index = 0. BYTE_VALID and FRAME_END are ignored here.
  - COLLECT: each BYTE_VALID stores the byte at the current index and increments the index.
    - On storing index 5, go to WAIT_END.
    - FRAME_END before 6 bytes: discard the frame and go to IDLE.
  - WAIT_END: on FRAME_END, publish and go to IDLE.
    - BYTE_VALID here marks the frame overrun. It stays in WAIT_END, and FRAME_END then discards the frame instead of publishing.
- Publish: X/Y/Z_DATA, AXIS_FAULT update together; SAMPLE_VALID pulses; SAMPLE_COUNT += 1 (wraps).
- Discard: outputs X/Y/Z/AXIS_FAULT hold previous values; FRAME_ERROR pulses; ERROR_COUNT += 1 unless already saturated.
- FRAME_START while in COLLECT or WAIT_END: the current frame is discarded (error pulse, count) and a new frame starts at index 0.
- Simultaneous events, in priority order:
  - BYTE_VALID with FRAME_END in COLLECT: the byte is stored first, then the end is evaluated. A 6th byte arriving with FRAME_END publishes.
  - FRAME_START with BYTE_VALID: the byte is index 0 of the new frame.
  - FRAME_START with FRAME_END: the end is evaluated on the old frame first, then the new frame starts.
- Partial frame bytes are held in staging registers; published outputs never show a mix of two frames.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, index = 0.
  - X/Y/Z_DATA = 0, AXIS_FAULT = 0.
  - SAMPLE_VALID = 0, FRAME_ERROR = 0, BUSY = 0.
  - SAMPLE_COUNT = 0, ERROR_COUNT = 0, staging registers = 0.
- RESET asserted mid-frame: the frame is lost, with no error count and no strobe.
- Input pulses are sampled on the CLK edge. Outputs are registered.
- SAMPLE_VALID/FRAME_ERROR assert on the edge that samples FRAME_END, are visible the following cycle, and last exactly 1 cycle.
- X/Y/Z_DATA change in the same cycle SAMPLE_VALID is high and hold until the next publish.
- SAMPLE_COUNT/ERROR_COUNT update in the same cycle as their strobe.
- BUSY rises the cycle after FRAME_START is sampled and falls the cycle after the terminating FRAME_END.
- No backpressure: every BYTE_VALID is accepted or counted as overrun. Back-to-back BYTE_VALID on consecutive cycles is supported.

## Test plan
- Normal frame: FRAME_START, bytes 0x34,0x01,0xFF,0xFF,0x00,0xF8, FRAME_END.
  - Required: X=0x134, Y=0xFFF (-1), Z=0x800 (-2048), AXIS_FAULT=000, one SAMPLE_VALID, SAMPLE_COUNT=1.
- Sign fault: as above but XH=0x51.
  - Required: X=0x134 published, AXIS_FAULT=001.
- Short frame: 4 bytes then FRAME_END.
  - Required: FRAME_ERROR pulse, ERROR_COUNT=1, X/Y/Z unchanged, no SAMPLE_VALID.
- Overrun: 7 bytes then FRAME_END.
  - Required: discard, ERROR_COUNT +1. Then FRAME_START with BYTE_VALID on the same edge followed by 5 more bytes publishes correctly.
- Edge cases:
  - 6th byte arriving in the same cycle as FRAME_END publishes.
  - ERROR_COUNT is held at 0xFF after 260 short frames.
  - SAMPLE_COUNT wraps 0xFFFF -> 0x0000 (preload via 65536 frames, or COUNT_WIDTH=4 with 16 frames).
- Async reset asserted between bytes 3 and 4 with no clock edge.
  - Required: all outputs go to reset values immediately. A subsequent full frame publishes with SAMPLE_COUNT=1.
